ext_arbiter: RTL and testbench
==============================

# ext_arbiter

Arbitrates a single shared 12-to-32-bit extension unit between two requesters (immediate path and load-data path). Accepts one request per cycle via valid/ready, extends it to 32 bits (sign or zero per request), and holds the result in a one-entry output register with backpressure. Fairness is round-robin. Sits between the decode/load stages and the ALU operand muxes.

## Interface

- DW, 12, input data width
- OW, 32, result width (OW > DW)
- Reset is synchronous and active-high; single clock.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_data  in  DW  requester 0 operand
- req0_signed  in  1  1 = sign-extend, 0 = zero-extend
- req1_valid / req1_ready / req1_data / req1_signed: same as above for requester 1
- res_valid  out  1  result register holds valid data
- res_ready  in  1  consumer takes result this cycle
- res_data  out  OW  extended result
- res_id  out  1  requester index that produced res_data

## Operation

- States: EMPTY (res_valid=0), FULL (res_valid=1).
- Slot free this cycle: `free = !res_valid || res_ready`.
- Grant selection, combinational: only one valid → that one; both valid → the one ≠ `last_grant`; none → no grant.
- `reqX_ready = free && grant==X`; at most one ready high per cycle; ready never high while reqX_valid is low.
- Accept (reqX_valid && reqX_ready): load res_data = ext(reqX_data, reqX_signed), res_id = X, res_valid=1, last_grant = X.
- Drain without accept (res_valid && res_ready && no grant): res_valid→0; res_data/res_id keep last value.
- Simultaneous drain and accept: new result loads; res_valid stays 1 (FULL→FULL).
- FULL && !res_ready: no accept; res_data, res_id stable.
- Extension: signed → bits OW-1:DW = data[DW-1]; unsigned → zeros; low DW bits = data unchanged.
- Requesters hold valid/data/signed stable until accepted; the block does not depend on that for correctness but does not latch unaccepted requests.
- Reset: res_valid=0, res_data=0, res_id=0, last_grant=1 (requester 0 wins first tie); any in-flight result is discarded.

## Timing

- Latency: accept in cycle N → res_valid/res_data visible in cycle N+1.
- Throughput: 1 result/cycle while res_ready=1 and any request is valid.
- Fairness: under continuous contention grants alternate 0,1,0,1…; worst-case wait = 1 grant.
- reqX_ready depends combinationally on res_ready, res_valid, both reqX_valid, last_grant; no path from ready back to valid.
- rst asserted in a cycle overrides accept and drain; outputs take reset values next edge; readies are 0 while rst=1.

## Structure

- Package `ext_pkg`: DW, OW constants; `typedef logic req_id_t`; enum `ext_mode_e {EXT_ZERO, EXT_SIGN}`; enum `res_state_e {EMPTY, FULL}`.
- Sub-module `ext_unit`: purely combinational DW→OW extender (data, mode → result); instantiated once, fed by the granted requester mux.
- Top holds grant logic, last_grant flop, output register and state.

## Test plan

- Reset: rst=1 two cycles with both valid → readies 0, res_valid=0, res_data=0, res_id=0.
- Single signed: req0 data=12'hae0, signed=1, res_ready=1 → req0_ready same cycle; next cycle res_valid=1, res_data=32'hFFFFFAE0, res_id=0.
- Single unsigned: req1 data=12'hae0, signed=0 → res_data=32'h00000AE0, res_id=1; data=12'h7FF signed=1 → 32'h000007FF.
- Contention: both valid continuously for 6 cycles after reset, res_ready=1 → res_id sequence 0,1,0,1,0,1, one result per cycle.
- Backpressure: result FULL, res_ready=0 for 3 cycles with req0 valid → req0_ready=0, res_data stable; res_ready=1 → drain and accept same cycle, res_valid stays 1, new data next cycle.
- Mid-operation reset: FULL with pending contention, assert rst one cycle → next cycle res_valid=0; first grant after release goes to req0 on tie.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared widths, requester id and enums for the extension arbiter
package ext_pkg;
  localparam int DW = 12;
  localparam int OW = 32;
  typedef logic req_id_t;
  typedef enum logic {EXT_ZERO, EXT_SIGN} ext_mode_e;
  typedef enum logic {EMPTY, FULL} res_state_e;
endpackage

// File: rtl/ext_unit.sv
// ext_unit: combinational DW->OW extender (data, mode in; result out)
module ext_unit import ext_pkg::*; (
  input  logic [DW-1:0] data,
  input  ext_mode_e     mode,
  output logic [OW-1:0] result
);
  assign result = {{(OW-DW){mode == EXT_SIGN && data[DW-1]}}, data};
endmodule

// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin arbiter for two requesters (reqX valid/ready/data/signed) into one extender with a one-entry result register (res valid/ready/data/id)
module ext_arbiter import ext_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_signed,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_signed,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res_data,
  output logic          res_id
);
  res_state_e    state, next_state;
  req_id_t       last_grant, grant;
  logic          free, accept;
  logic [DW-1:0] sel_data;
  logic [OW-1:0] ext_res;
  ext_mode_e     sel_mode;
  assign res_valid = state == FULL;
  assign free = !res_valid || res_ready;
  always_comb begin
    grant = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    accept = !rst && free && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_data = grant ? req1_data : req0_data;
    sel_mode = ext_mode_e'(grant ? req1_signed : req0_signed);
    next_state = accept ? FULL : (res_valid && res_ready) ? EMPTY : state;
  end
  ext_unit u_ext (
    .data   (sel_data),
    .mode   (sel_mode),
    .result (ext_res)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      if (accept) begin
        res_data   <= ext_res;
        res_id     <= grant;
        last_grant <= grant;
      end
    end
  end
endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: directed self-checking bench for ext_arbiter
module tb_ext_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_signed;
  logic        req1_valid, req1_ready, req1_signed;
  logic [11:0] req0_data, req1_data;
  logic        res_valid, res_ready, res_id;
  logic [31:0] res_data;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  ext_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req0_signed (req0_signed),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .req1_signed (req1_signed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_id      (res_id)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk_res(input string tag, input logic v, input logic [31:0] d, input logic id);
    chk({tag, "_valid"}, res_valid, v);
    chk({tag, "_data"}, res_data, d);
    chk({tag, "_id"}, res_id, id);
  endtask
  initial begin
    rst = 1; res_ready = 1;
    req0_valid = 1; req0_data = 12'h123; req0_signed = 0;
    req1_valid = 1; req1_data = 12'h456; req1_signed = 0;
    tick();
    chk("rst_r0", req0_ready, 0);
    chk("rst_r1", req1_ready, 0);
    chk_res("rst_a", 0, 32'h0, 0);
    tick();
    chk("rst_r0b", req0_ready, 0);
    chk("rst_r1b", req1_ready, 0);
    chk_res("rst_b", 0, 32'h0, 0);
    rst = 0; req1_valid = 0; req0_data = 12'hae0; req0_signed = 1;
    settle();
    chk("sgn_r0", req0_ready, 1);
    chk("sgn_r1", req1_ready, 0);
    tick();
    chk_res("sgn", 1, 32'hFFFFFAE0, 0);
    req0_valid = 0; req1_valid = 1; req1_data = 12'hae0; req1_signed = 0;
    settle();
    chk("uns_r0", req0_ready, 0);
    chk("uns_r1", req1_ready, 1);
    tick();
    chk_res("uns", 1, 32'h00000AE0, 1);
    req1_data = 12'h7ff; req1_signed = 1;
    tick();
    chk_res("pos", 1, 32'h000007FF, 1);
    rst = 1;
    tick();
    rst = 0; req0_valid = 1; req0_data = 12'h001; req0_signed = 0;
    req1_valid = 1; req1_data = 12'h002; req1_signed = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("rr_r0", req0_ready, (i % 2) == 0);
      chk("rr_r1", req1_ready, (i % 2) == 1);
      tick();
      chk_res("rr", 1, (i % 2) ? 32'h2 : 32'h1, (i % 2) == 1);
    end
    req1_valid = 0; req0_data = 12'h800; req0_signed = 1; res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_r0", req0_ready, 0);
      tick();
      chk_res("bp", 1, 32'h2, 1);
    end
    res_ready = 1;
    settle();
    chk("bp_rel_r0", req0_ready, 1);
    tick();
    chk_res("bp_rel", 1, 32'hFFFFF800, 0);
    req0_valid = 0;
    settle();
    chk("drain_r0", req0_ready, 0);
    tick();
    chk_res("drain", 0, 32'hFFFFF800, 0);
    req0_valid = 1; req0_data = 12'h003; req0_signed = 0;
    req1_valid = 1; req1_data = 12'h004; req1_signed = 0;
    tick();
    chk_res("pre_rst", 1, 32'h4, 1);
    res_ready = 0; rst = 1;
    settle();
    chk("mrst_r0", req0_ready, 0);
    chk("mrst_r1", req1_ready, 0);
    tick();
    chk_res("mrst", 0, 32'h0, 0);
    rst = 0; res_ready = 1;
    settle();
    chk("post_r0", req0_ready, 1);
    chk("post_r1", req1_ready, 0);
    tick();
    chk_res("post", 1, 32'h3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
